// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encoding, FSM states and result-flag constants shared by mc_alu
// MC_ALU_DIV_EN is honoured by the datapath; the encoding here is fixed.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_NOT = 4'b0010,
    OP_ADD = 4'b0011,
    OP_SUB = 4'b0100,
    OP_MUL = 4'b0101,
    OP_DIV = 4'b0110,
    OP_SHL = 4'b0111,
    OP_SHR = 4'b1000,
    OP_ROR = 4'b1001
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Packed as {err, zero}
  typedef logic [1:0] flags_t;
  localparam flags_t FLAGS_RESET   = 2'b01;
  localparam flags_t FLAGS_ILLEGAL = 2'b11;
  localparam flags_t FLAGS_DIV0    = 2'b10;

  function automatic logic is_single_cycle(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_NOT, OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_ROR: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative radix-2 Booth multiplier and signed restoring divider
// The divider half is only present when MC_ALU_DIV_EN is defined.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               mode,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] m_q;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic             mode_q;

  // One guard bit on the accumulator keeps A-M from overflowing when M is most-negative.
  assign m_ext = {m_q[WIDTH-1], m_q};

  always_comb begin
    booth_sum = acc_q;
    case ({qr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
  end

`ifdef MC_ALU_DIV_EN
  logic             negq_q, negr_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;

  assign a_mag   = a[WIDTH-1] ? -a : a;
  assign b_mag   = b[WIDTH-1] ? -b : b;
  assign shifted = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, m_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (load) begin
      mode_q <= mode;
      negq_q <= a[WIDTH-1] ^ b[WIDTH-1];
      negr_q <= a[WIDTH-1];
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_q      = 1'b0;
`endif

  always_comb begin
    acc_d = acc_q;
    qr_d  = qr_q;
    qm1_d = qm1_q;
    if (step) begin
      if (!mode_q) begin
        acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        qr_d  = {booth_sum[0], qr_q[WIDTH-1:1]};
        qm1_d = qr_q[0];
      end
`ifdef MC_ALU_DIV_EN
      else if (trial[WIDTH]) begin
        acc_d = shifted;
        qr_d  = {qr_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = trial;
        qr_d  = {qr_q[WIDTH-2:0], 1'b1};
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      qr_q  <= '0;
      m_q   <= '0;
      qm1_q <= 1'b0;
    end else if (load) begin
      acc_q <= '0;
      qm1_q <= 1'b0;
`ifdef MC_ALU_DIV_EN
      if (mode) begin
        qr_q <= a_mag;
        m_q  <= b_mag;
      end else begin
        qr_q <= b;
        m_q  <= a;
      end
`else
      qr_q <= b;
      m_q  <= a;
`endif
    end else begin
      acc_q <= acc_d;
      qr_q  <= qr_d;
      qm1_q <= qm1_d;
    end
  end

  // Results reflect the value after this cycle's step so the FSM can capture them on the last edge.
  assign product = {acc_d[WIDTH-1:0], qr_d};

`ifdef MC_ALU_DIV_EN
  assign quotient  = negq_q ? -qr_d : qr_d;
  assign remainder = negr_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
`else
  assign quotient  = '0;
  assign remainder = '0;
`endif

endmodule

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU top: FSM, RUN counter and result registers
// Define MC_ALU_DIV_EN to make op 0110 a signed divide; otherwise it is illegal.
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             err
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = SHW + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  state_e           state_q;
  logic [CNTW-1:0]  cnt_q;
  logic             busy_q, done_q, zero_q, err_q, div_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] rot_wide;
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]   run_hi_d, run_lo_d;
  logic               single_op, is_mul, is_div;
  logic               md_load, md_step;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient, remainder;

  assign amt       = b[SHW-1:0];
  assign single_op = is_single_cycle(op);
  assign is_mul    = (op == OP_MUL);
`ifdef MC_ALU_DIV_EN
  assign is_div    = (op == OP_DIV);
`else
  assign is_div    = 1'b0;
`endif

  // Divide-by-zero never enters RUN, so only a nonzero divisor loads the datapath.
  assign md_load = (state_q == ST_IDLE) && start && (is_mul || (is_div && (b != '0)));
  assign md_step = (state_q == ST_RUN);

  always_comb begin
    rot_wide = {a, a} >> amt;
    res_d    = '0;
    case (op)
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_NOT:  res_d = ~a;
      OP_ADD:  res_d = a + b;
      OP_SUB:  res_d = a - b;
      OP_SHL:  res_d = a << amt;
      OP_SHR:  res_d = a >> amt;
      OP_ROR:  res_d = rot_wide[WIDTH-1:0];
      default: res_d = '0;
    endcase
  end

  assign run_hi_d = div_q ? remainder : product[2*WIDTH-1:WIDTH];
  assign run_lo_d = div_q ? quotient  : product[WIDTH-1:0];

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (md_load),
    .mode     (is_div),
    .step     (md_step),
    .a        (a),
    .b        (b),
    .product  (product),
    .quotient (quotient),
    .remainder(remainder)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      div_q           <= 1'b0;
      hi_q            <= '0;
      lo_q            <= '0;
      {err_q, zero_q} <= FLAGS_RESET;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            div_q <= is_div;
            cnt_q <= '0;
            if (md_load) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              if (is_div) begin
                hi_q            <= a;
                lo_q            <= '1;
                {err_q, zero_q} <= FLAGS_DIV0;
              end else if (single_op) begin
                hi_q   <= '0;
                lo_q   <= res_d;
                err_q  <= 1'b0;
                zero_q <= (res_d == '0);
              end else begin
                hi_q            <= '0;
                lo_q            <= '0;
                {err_q, zero_q} <= FLAGS_ILLEGAL;
              end
            end
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= run_hi_d;
            lo_q    <= run_lo_d;
            err_q   <= 1'b0;
            zero_q  <= ({run_hi_d, run_lo_d} == '0);
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign zero = zero_q;
  assign err  = err_q;

endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - directed bench for mc_alu at WIDTH=32 and WIDTH=16
module tb_mc_alu;

  localparam logic [3:0] C_AND = 4'h0, C_OR = 4'h1, C_NOT = 4'h2, C_ADD = 4'h3, C_SUB = 4'h4;
  localparam logic [3:0] C_MUL = 4'h5, C_DIV = 4'h6, C_SHL = 4'h7, C_SHR = 4'h8, C_ROR = 4'h9;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, zero, err;

  logic        s16_start;
  logic [3:0]  s16_op;
  logic [15:0] s16_a, s16_b, s16_hi, s16_lo;
  logic        s16_busy, s16_done, s16_zero, s16_err;

  int errors = 0;
  int checks = 0;

  mc_alu #(.WIDTH(32)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .zero(zero), .err(err)
  );

  mc_alu #(.WIDTH(16)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .start(s16_start), .op(s16_op), .a(s16_a), .b(s16_b),
    .busy(s16_busy), .done(s16_done), .hi(s16_hi), .lo(s16_lo), .zero(s16_zero), .err(s16_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    for (int i = 1; i <= limit && lat == 0; i++) begin
      @(negedge clock);
      if (busy) nbusy++;
      if (done) lat = i;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; op = 4'h0; a = '0; b = '0;
    s16_start = 1'b0; s16_op = 4'h0; s16_a = '0; s16_b = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, zero, err} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/zero/err=%b expected 0010", {busy, done, zero, err});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 0", {hi, lo});
    end
    checks++;
    if ({s16_busy, s16_done, s16_zero, s16_err, s16_hi, s16_lo} !== {4'b0010, 32'h0}) begin
      errors++;
      $display("FAIL reset_w16: got %b %h %h expected 0010 0 0",
               {s16_busy, s16_done, s16_zero, s16_err}, s16_hi, s16_lo);
    end
  endtask

  task automatic test_first_start;
    int lat, nb;
    @(negedge clock);
    reset_n = 1'b1;
    op = C_ADD; a = 32'hFFFF_FFFF; b = 32'd1; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(5, lat, nb);
    checks++;
    if (lat !== 1 || nb !== 0) begin
      errors++;
      $display("FAIL first_add_latency: got lat=%0d busy=%0d expected lat=1 busy=0", lat, nb);
    end
    checks++;
    if ({hi, lo, zero, err} !== {64'h0, 2'b10}) begin
      errors++;
      $display("FAIL add_wrap: got hi=%h lo=%h zero=%b err=%b expected 0 0 1 0", hi, lo, zero, err);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got done=%b expected 0", done);
    end
  endtask

  task automatic test_single_ops;
    vec_t v[12];
    int lat, nb;
    v[0]  = '{C_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 32'h00F0_1200, 1'b0, 1'b0, 1};
    v[1]  = '{C_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 32'hFFF0_FF34, 1'b0, 1'b0, 1};
    v[2]  = '{C_NOT, 32'h0000_FFFF, 32'h1234_5678, 32'h0, 32'hFFFF_0000, 1'b0, 1'b0, 1};
    v[3]  = '{C_SUB, 32'd5,         32'd7,         32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
    v[4]  = '{C_SUB, 32'h8000_0000, 32'd1,         32'h0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1};
    v[5]  = '{C_SHL, 32'h0000_0001, 32'h0000_0024, 32'h0, 32'h0000_0010, 1'b0, 1'b0, 1};
    v[6]  = '{C_SHR, 32'h8000_0000, 32'd31,        32'h0, 32'h0000_0001, 1'b0, 1'b0, 1};
    v[7]  = '{C_ROR, 32'h0000_0001, 32'd1,         32'h0, 32'h8000_0000, 1'b0, 1'b0, 1};
    v[8]  = '{C_ROR, 32'h1234_5678, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1};
    v[9]  = '{C_AND, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 1};
    v[10] = '{C_SHL, 32'hFFFF_FFFF, 32'd31,        32'h0, 32'h8000_0000, 1'b0, 1'b0, 1};
    v[11] = '{C_ROR, 32'h1234_5678, 32'd4,         32'h0, 32'h8123_4567, 1'b0, 1'b0, 1};
    for (int i = 0; i < 12; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(5, lat, nb);
      checks++;
      if (lat !== v[i].lat || nb !== 0 || hi !== v[i].hi || lo !== v[i].lo ||
          zero !== v[i].zero || err !== v[i].err) begin
        errors++;
        $display("FAIL single[%0d]: got lat=%0d busy=%0d hi=%h lo=%h zero=%b err=%b expected lat=%0d busy=0 hi=%h lo=%h zero=%b err=%b",
                 i, lat, nb, hi, lo, zero, err, v[i].lat, v[i].hi, v[i].lo, v[i].zero, v[i].err);
      end
    end
  endtask

  task automatic test_illegal;
    vec_t v[3];
    int lat, nb;
    v[0] = '{4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 1'b1, 1'b1, 1};
    v[1] = '{4'hA, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0, 1'b1, 1'b1, 1};
    v[2] = '{C_ADD, 32'd40,       32'd2,         32'h0, 32'd42, 1'b0, 1'b0, 1};
    for (int i = 0; i < 3; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(5, lat, nb);
      checks++;
      if (lat !== v[i].lat || hi !== v[i].hi || lo !== v[i].lo || zero !== v[i].zero || err !== v[i].err) begin
        errors++;
        $display("FAIL illegal[%0d]: got lat=%0d hi=%h lo=%h zero=%b err=%b expected lat=%0d hi=%h lo=%h zero=%b err=%b",
                 i, lat, hi, lo, zero, err, v[i].lat, v[i].hi, v[i].lo, v[i].zero, v[i].err);
      end
    end
  endtask

  task automatic test_mul;
    vec_t v[5];
    int lat, nb;
    v[0] = '{C_MUL, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 33};
    v[1] = '{C_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 33};
    v[2] = '{C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 33};
    v[3] = '{C_MUL, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 1'b0, 33};
    v[4] = '{C_MUL, 32'h0001_2345, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 33};
    for (int i = 0; i < 5; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(40, lat, nb);
      checks++;
      if (lat !== v[i].lat || nb !== 32 || hi !== v[i].hi || lo !== v[i].lo ||
          zero !== v[i].zero || err !== v[i].err) begin
        errors++;
        $display("FAIL mul[%0d]: got lat=%0d busy=%0d hi=%h lo=%h zero=%b err=%b expected lat=%0d busy=32 hi=%h lo=%h zero=%b err=%b",
                 i, lat, nb, hi, lo, zero, err, v[i].lat, v[i].hi, v[i].lo, v[i].zero, v[i].err);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int ndone, first;
    logic [63:0] got;
    ndone = 0; first = 0; got = '0;
    issue(C_MUL, 32'h0001_0000, 32'h0000_0030);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = n;
          got = {hi, lo};
        end
      end
      if (n == 5) begin
        start = 1'b1; op = C_AND; a = 32'h0; b = 32'h0;
      end
      if (n == 6) start = 1'b0;
      if (n == 10) a = 32'hFFFF_FFFF;
    end
    checks++;
    if (ndone !== 1 || first !== 33) begin
      errors++;
      $display("FAIL busy_start_ignored: got dones=%0d first=%0d expected dones=1 first=33", ndone, first);
    end
    checks++;
    if (got !== 64'h0000_0000_0030_0000) begin
      errors++;
      $display("FAIL latched_operands: got %h expected 0000000000300000", got);
    end
  endtask

  task automatic test_div;
    vec_t v[6];
    int n, lat, nb;
`ifdef MC_ALU_DIV_EN
    n = 6;
    v[0] = '{C_DIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 33};
    v[1] = '{C_DIV, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 1'b1, 1};
    v[2] = '{C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 33};
    v[3] = '{C_DIV, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 33};
    v[4] = '{C_DIV, 32'hFFFF_FFF8, 32'h8000_0000, 32'hFFFF_FFF8, 32'h0000_0000, 1'b0, 1'b0, 33};
    v[5] = '{C_DIV, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 1'b0, 33};
`else
    n = 2;
    v[0] = '{C_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b1, 1'b1, 1};
    v[1] = '{C_DIV, 32'd5,         32'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1};
`endif
    for (int i = 0; i < n; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(40, lat, nb);
      checks++;
      if (lat !== v[i].lat || hi !== v[i].hi || lo !== v[i].lo || zero !== v[i].zero || err !== v[i].err) begin
        errors++;
        $display("FAIL div[%0d]: got lat=%0d hi=%h lo=%h zero=%b err=%b expected lat=%0d hi=%h lo=%h zero=%b err=%b",
                 i, lat, hi, lo, zero, err, v[i].lat, v[i].hi, v[i].lo, v[i].zero, v[i].err);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int ndone, nbusy;
`ifdef MC_ALU_DIV_EN
    issue(C_DIV, 32'd1000, 32'd7);
`else
    issue(C_MUL, 32'd1000, 32'd7);
`endif
    repeat (11) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_run: got busy=%b expected 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, zero, err, hi, lo} !== {4'b0010, 64'h0}) begin
      errors++;
      $display("FAIL async_reset: got flags=%b hi=%h lo=%h expected 0010 0 0", {busy, done, zero, err}, hi, lo);
    end
    @(negedge clock);
    reset_n = 1'b1;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    checks++;
    if (ndone !== 0 || nbusy !== 0) begin
      errors++;
      $display("FAIL abort_after_reset: got dones=%0d busy=%0d expected 0 0", ndone, nbusy);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] pat;
    pat = '0;
    @(negedge clock);
    op = C_ADD; a = 32'd1; b = 32'd2; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      pat = {pat[4:0], done};
    end
    start = 1'b0;
    checks++;
    if (pat !== 6'b101010 || lo !== 32'd3) begin
      errors++;
      $display("FAIL back_to_back: got pattern=%b lo=%h expected 101010 00000003", pat, lo);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_w16;
    logic [3:0]  t_op[4];
    logic [15:0] t_a[4], t_b[4], t_hi[4], t_lo[4];
    logic [1:0]  t_fl[4];
    int          t_lat[4];
    int lat;
    t_op[0] = C_ROR; t_a[0] = 16'h0001; t_b[0] = 16'h0001; t_hi[0] = 16'h0;    t_lo[0] = 16'h8000; t_fl[0] = 2'b00; t_lat[0] = 1;
    t_op[1] = 4'hF;  t_a[1] = 16'h1234; t_b[1] = 16'h5678; t_hi[1] = 16'h0;    t_lo[1] = 16'h0;    t_fl[1] = 2'b11; t_lat[1] = 1;
    t_op[2] = C_MUL; t_a[2] = 16'hFFFD; t_b[2] = 16'h0007; t_hi[2] = 16'hFFFF; t_lo[2] = 16'hFFEB; t_fl[2] = 2'b00; t_lat[2] = 17;
`ifdef MC_ALU_DIV_EN
    t_op[3] = C_DIV; t_a[3] = 16'h7FFF; t_b[3] = 16'h0003; t_hi[3] = 16'h0001; t_lo[3] = 16'h2AAA; t_fl[3] = 2'b00; t_lat[3] = 17;
`else
    t_op[3] = C_DIV; t_a[3] = 16'h7FFF; t_b[3] = 16'h0003; t_hi[3] = 16'h0;    t_lo[3] = 16'h0;    t_fl[3] = 2'b11; t_lat[3] = 1;
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      s16_op = t_op[i]; s16_a = t_a[i]; s16_b = t_b[i]; s16_start = 1'b1;
      @(posedge clock);
      #1 s16_start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 25 && lat == 0; k++) begin
        @(negedge clock);
        if (s16_done) lat = k;
      end
      checks++;
      if (lat !== t_lat[i] || s16_hi !== t_hi[i] || s16_lo !== t_lo[i] || {s16_err, s16_zero} !== t_fl[i]) begin
        errors++;
        $display("FAIL w16[%0d]: got lat=%0d hi=%h lo=%h err/zero=%b expected lat=%0d hi=%h lo=%h err/zero=%b",
                 i, lat, s16_hi, s16_lo, {s16_err, s16_zero}, t_lat[i], t_hi[i], t_lo[i], t_fl[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_start();
    test_single_ops();
    test_illegal();
    test_mul();
    test_start_while_busy();
    test_div();
    test_reset_mid_run();
    test_back_to_back();
    test_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; legal values are even and at least 8.
REQ-002 SHALL have port clock, input, 1 bit: single rising-edge clock.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: op/a/b valid, sampled only when busy=0.
REQ-005 SHALL have port op, input, 4 bits: 0000 AND, 0001 OR, 0010 NOT, 0011 ADD, 0100 SUB, 0101 MUL, 0110 DIV, 0111 SHL, 1000 SHR (logical), 1001 ROR; all other codes are illegal.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: signed two's-complement operands.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 SHALL have ports hi and lo, output, WIDTH bits each: result registers, held until the next done.
REQ-010 SHALL have port zero, output, 1 bit: {hi,lo}==0, updated with done.
REQ-011 SHALL have port err, output, 1 bit: illegal op or divide-by-zero, updated with done.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; start is accepted only in IDLE.
REQ-013 For single-cycle ops (AND/OR/NOT/ADD/SUB/SHL/SHR/ROR), SHALL go IDLE->DONE, with done asserted in the cycle after start; hi=0, lo=result.
REQ-014 ADD/SUB SHALL wrap modulo 2^WIDTH; the carry is discarded.
REQ-015 SHL/SHR/ROR SHALL use b[$clog2(WIDTH)-1:0] as the amount; amount 0 leaves a unchanged.
REQ-016 MUL SHALL be iterative radix-2 Booth: IDLE->RUN for WIDTH cycles, then DONE; {hi,lo} is the signed 2*WIDTH product; latency is WIDTH+1 cycles from start to done.
REQ-017 DIV SHALL be iterative signed restoring division: WIDTH cycles in RUN; lo=quotient truncated toward zero; hi=remainder with the sign of a.
REQ-018 DIV with b=0 SHALL skip RUN: done after 1 cycle, err=1, hi=a, lo=all-ones.
REQ-019 DIV of most-negative by -1 SHALL give lo=most-negative, hi=0, err=0.
REQ-020 An illegal op SHALL complete in 1 cycle with hi=lo=0, zero=1, err=1.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE; start is accepted again only in IDLE, so back-to-back single-cycle ops run one per 2 cycles.
REQ-022 A start while busy=1 SHALL be ignored with no side effect.
REQ-023 Operands SHALL be latched at acceptance; changes to a/b/op while busy SHALL not affect the result.
REQ-024 The RUN cycle counter SHALL be $clog2(WIDTH)+1 bits and SHALL not wrap before terminal count.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: state=IDLE, busy=0, done=0, hi=0, lo=0, zero=1, err=0, internal counter and accumulators=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; after release no done is produced for the aborted op.
REQ-027 The first start SHALL be accepted in the first rising edge after reset_n deasserts.

Configuration
REQ-028 Macro MC_ALU_DIV_EN defined SHALL build the divider per REQ-017 to REQ-019.
REQ-029 Without MC_ALU_DIV_EN, the divider logic SHALL be absent and op 0110 SHALL be treated as illegal per REQ-020.

Structure
REQ-030 Shared package alu_pkg SHALL hold the op encoding enum, the FSM state typedef and the result-flag constants.
REQ-031 The MUL/DIV datapath SHALL be sub-module muldiv_iter (parameter WIDTH; ports load, mode, step, product/quotient/remainder); mc_alu SHALL own the FSM, counter and result registers.

Verification
REQ-032 WIDTH=32: ADD a=0xFFFFFFFF, b=1, start for 1 cycle -> done on the next cycle, lo=0, hi=0, zero=1, err=0.
REQ-033 MUL a=-3, b=7 -> done exactly 33 cycles after start; {hi,lo}=0xFFFFFFFF_FFFFFFEB; busy high for 32 cycles.
REQ-034 DIV a=-7, b=2 -> lo=-3 (0xFFFFFFFD), hi=-1; then DIV a=5, b=0 -> done after 1 cycle, err=1, lo=0xFFFFFFFF, hi=5.
REQ-035 MUL started, then start with op=AND asserted at cycle 5 and a changed at cycle 10 -> single done at cycle 33 carrying the original product only.
REQ-036 reset_n low at cycle 12 of a DIV -> outputs take reset values immediately; no done for 40 cycles after release without a start.
REQ-037 WIDTH=16: ROR a=0x0001, b=1 -> lo=0x8000; op=1111 -> err=1, zero=1; build without MC_ALU_DIV_EN, op=0110 -> err=1.
